// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the arbitrated ALU.
// Imported by alu_arbiter and its ALU datapath.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU; unsupported opcodes return zero and raise err.
// Add/sub wrap at the data width, carry/borrow are dropped.
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int n = 63
) (
   input  logic [3:0] op,
   input  logic [n:0] a,
   input  logic [n:0] b,
   output logic [n:0] result,
   output logic       err
);

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_ADD:   result = a + b;
         OP_SUB:   result = a - b;
         OP_PASSB: result = b;
         OP_NOR:   result = ~(a | b);
         default:  err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU: accept one request,
// execute it for one cycle, then hold the registered response until consumed.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int n = 63
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_op,
   input  logic [n:0] req0_a,
   input  logic [n:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_op,
   input  logic [n:0] req1_a,
   input  logic [n:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [n:0] rsp_result,
   output logic       rsp_zero,
   output logic       rsp_err
);

   state_t     state_reg, state_next;
   logic       last_grant_reg;
   logic       id_reg;
   logic [3:0] op_reg;
   logic [n:0] a_reg, b_reg;
   logic [n:0] result_reg;
   logic       zero_reg, err_reg;

   logic       grant_id;
   logic       accept;
   logic [n:0] alu_result;
   logic       alu_err;

   // Contention goes to whoever did not win last; a lone requester always wins.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid)
         grant_id = ~last_grant_reg;
      else if (req1_valid)
         grant_id = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               accept     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Reset gating keeps ready low while reset is held, even with valid high.
   assign req0_ready = accept && !grant_id && !reset;
   assign req1_ready = accept &&  grant_id && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         id_reg         <= 1'b0;
         op_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            op_reg         <= grant_id ? req1_op : req0_op;
            a_reg          <= grant_id ? req1_a  : req0_a;
            b_reg          <= grant_id ? req1_b  : req0_b;
         end
         if (state_reg == EXEC) begin
            result_reg <= alu_result;
            err_reg    <= alu_err;
            zero_reg   <= (alu_result == '0) && !alu_err;
         end
      end
   end

   alu_arbiter_alu #(
      .n(n)
   ) u_alu (
      .op     (op_reg),
      .a      (a_reg),
      .b      (b_reg),
      .result (alu_result),
      .err    (alu_err)
   );

   assign rsp_valid  = (state_reg == RESP);
   assign rsp_id     = id_reg;
   assign rsp_result = result_reg;
   assign rsp_zero   = zero_reg;
   assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a behavioural model
// of the grant rule and the ALU operations.
module tb_alu_arbiter;

   localparam int N = 63;
   localparam int W = N + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready;
   logic [3:0]   req0_op;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready;
   logic [3:0]   req1_op;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [W-1:0] rsp_result;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   bit last_g = 1'b1;

   always #5 clk = ~clk;

   alu_arbiter #(.n(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: returns {err, result} from the opcode table.
   function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] all_ones;
      all_ones = '1;
      case (op)
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0010: return {1'b0, a + b};
         4'b0110: return {1'b0, a - b};
         4'b0111: return {1'b0, b};
         4'b1100: return {1'b0, all_ones ^ (a | b)};
         default: return {1'b1, {W{1'b0}}};
      endcase
   endfunction

   function automatic logic [W-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [3:0] rand_op();
      logic [3:0] ops [8];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
      if ($urandom_range(0, 9) == 0) return 4'($urandom);
      return ops[$urandom_range(0, 7)];
   endfunction

   task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (i == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // Called #1 after a clock edge with the DUT idle and at least one valid high.
   task automatic run_txn(input string tag, input int hold);
      bit           g;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic [W:0]   exp;
      #1;
      g = (req0_valid && req1_valid) ? !last_g : req1_valid;
      check({tag, ".ready0"}, W'(req0_ready), W'(!g));
      check({tag, ".ready1"}, W'(req1_ready), W'(g));
      op  = g ? req1_op : req0_op;
      a   = g ? req1_a  : req0_a;
      b   = g ? req1_b  : req0_b;
      exp = ref_alu(op, a, b);
      @(posedge clk); #1;
      last_g = g;
      // The winner withdraws and scribbles its inputs; the in-flight op must not care.
      if (g) begin
         req1_valid = 1'b0; req1_op = 4'($urandom); req1_a = rand_word(); req1_b = rand_word();
      end else begin
         req0_valid = 1'b0; req0_op = 4'($urandom); req0_a = rand_word(); req0_b = rand_word();
      end
      check({tag, ".exec_valid"}, W'(rsp_valid), W'(0));
      check({tag, ".exec_rdy"}, W'({req1_ready, req0_ready}), W'(0));
      @(posedge clk); #1;
      check({tag, ".rsp_valid"}, W'(rsp_valid), W'(1));
      check({tag, ".rsp_id"}, W'(rsp_id), W'(g));
      check({tag, ".result"}, rsp_result, exp[W-1:0]);
      check({tag, ".err"}, W'(rsp_err), W'(exp[W]));
      check({tag, ".zero"}, W'(rsp_zero), W'(exp[W-1:0] == 0 && !exp[W]));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, W'(rsp_valid), W'(1));
         check({tag, ".hold_result"}, rsp_result, exp[W-1:0]);
         check({tag, ".hold_rdy"}, W'({req1_ready, req0_ready}), W'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, ".done_valid"}, W'(rsp_valid), W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ones;
      int           pend0, pend1;
      ones = '1;
      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

      // Reset state, including ready held low under reset with valid high.
      @(posedge clk); @(posedge clk); #1;
      req0_valid = 1'b1;
      #1;
      check("rst.valid", W'(rsp_valid), W'(0));
      check("rst.ready0", W'(req0_ready), W'(0));
      check("rst.ready1", W'(req1_ready), W'(0));
      check("rst.id", W'(rsp_id), W'(0));
      check("rst.result", rsp_result, '0);
      check("rst.zero", W'(rsp_zero), W'(0));
      check("rst.err", W'(rsp_err), W'(0));
      req0_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // Add 5+7 from requester 0 right after reset.
      set_req(0, 4'b0010, W'(5), W'(7));
      run_txn("add", 0);
      check("add.const", rsp_result, W'(12));

      // Continuous contention with a zero result.
      for (int i = 0; i < 4; i++) begin
         if (!req0_valid) set_req(0, 4'b0110, W'(9), W'(9));
         if (!req1_valid) set_req(1, 4'b0110, W'(9), W'(9));
         run_txn("rr", 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Subtract wrap, pass-b, unsupported op with a stalled consumer.
      set_req(1, 4'b0110, W'(0), W'(1));
      run_txn("wrap", 0);
      check("wrap.ones", rsp_result, ones);
      set_req(1, 4'b0111, W'(3), W'(8));
      run_txn("passb", 0);
      set_req(1, 4'b0011, W'(4), W'(4));
      run_txn("badop", 5);

      // Reset during EXEC discards the transaction.
      set_req(0, 4'b0010, W'(1), W'(1));
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("rexec.valid", W'(rsp_valid), W'(0));
      check("rexec.ready0", W'(req0_ready), W'(0));
      check("rexec.id", W'(rsp_id), W'(0));
      check("rexec.err", W'(rsp_err), W'(0));
      check("rexec.result", rsp_result, '0);
      req0_valid = 1'b0;
      last_g = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rexec.no_rsp", W'(rsp_valid), W'(0));
      end
      set_req(0, 4'b0001, W'(6), W'(9));
      set_req(1, 4'b0000, W'(6), W'(9));
      run_txn("post_rst", 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Randomized traffic: pending requests persist until granted.
      for (int t = 0; t < 40; t++) begin
         pend0 = req0_valid; pend1 = req1_valid;
         if (!pend0 && $urandom_range(0, 1) == 1) begin
            set_req(0, rand_op(), rand_word(), rand_word());
            if ($urandom_range(0, 3) == 0) req0_b = req0_a;
         end
         if (!pend1 && $urandom_range(0, 1) == 1)
            set_req(1, rand_op(), rand_word(), $urandom_range(0, 2) == 0 ? W'(1) : rand_word());
         if (!req0_valid && !req1_valid)
            set_req(t % 2, rand_op(), W'(0), rand_word());
         run_txn("rand", $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
